// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, word size and default bit period.
// Used by both the receive and transmit paths.
package uart_pkg;

    localparam int UART_DATA_BITS       = 8;
    localparam int CLKS_PER_BIT_DEFAULT = 5208;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        DONE   = 3'd5
    } uart_state_t;

endpackage

// File: rtl/rx_sync_module.sv
// Two-flop synchronizer for the asynchronous rx pin plus a history flop
// that turns a synchronized high-to-low transition into a one-cycle fall pulse.
module rx_sync_module (
    input  logic sysclk,
    input  logic rst,
    input  logic rx,
    output logic level,
    output logic fall
);

    logic sync_a;
    logic sync_b;
    logic hist;

    // Reset to the idle line level so leaving reset never looks like a start edge.
    always_ff @(posedge sysclk) begin
        if (rst) begin
            sync_a <= 1'b1;
            sync_b <= 1'b1;
            hist   <= 1'b1;
        end else begin
            sync_a <= rx;
            sync_b <= sync_a;
            hist   <= sync_b;
        end
    end

    assign level = sync_b;
    assign fall  = ~sync_b & hist;

endmodule

// File: rtl/rx_frame_module.sv
// UART receive framer: start validation, mid-bit sampling of 8 data bits LSB
// first, optional parity check (macro RX_PARITY_EN), stop check and done strobe.
module rx_frame_module
    import uart_pkg::*;
#(
    parameter int   CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter logic PARITY_MODE  = 1'b0
) (
    input  logic                      sysclk,
    input  logic                      rst,
    input  logic                      rx_en_sig,
    input  logic                      rx,
    output logic [UART_DATA_BITS-1:0] rx_data,
    output logic                      rx_done_sig,
    output logic                      rx_busy,
    output logic                      parity_err,
    output logic                      frame_err
);

    localparam int                CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  HALF  = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]        LAST_BIT = 4'(UART_DATA_BITS - 1);

    uart_state_t               state;
    uart_state_t               state_next;
    logic [CNT_W-1:0]          baud_cnt;
    logic [3:0]                bit_cnt;
    logic [UART_DATA_BITS-1:0] shift;
    logic                      level;
    logic                      fall;
    logic                      mid;

    rx_sync_module u_sync (
        .sysclk (sysclk),
        .rst    (rst),
        .rx     (rx),
        .level  (level),
        .fall   (fall)
    );

    // baud_cnt equals (cycles since T0) mod CLKS_PER_BIT, so every sample lands on HALF.
    assign mid = (baud_cnt == HALF);

    always_ff @(posedge sysclk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (!rx_en_sig) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:   if (fall) state_next = START;
                START:  if (mid) state_next = level ? IDLE : DATA;
`ifdef RX_PARITY_EN
                DATA:   if (mid && bit_cnt == LAST_BIT) state_next = PARITY;
                PARITY: if (mid) state_next = STOP;
`else
                DATA:   if (mid && bit_cnt == LAST_BIT) state_next = STOP;
`endif
                STOP:   if (mid) state_next = DONE;
                DONE:   state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        rx_busy     = (state != IDLE);
        rx_done_sig = (state == DONE);
    end

    // Result registers load at the stop sample so they are valid during DONE.
    always_ff @(posedge sysclk) begin
        if (rst) begin
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift     <= '0;
            rx_data   <= '0;
            frame_err <= 1'b0;
        end else begin
            if (state == IDLE) begin
                if (fall) begin
                    baud_cnt <= CNT_W'(1);
                    bit_cnt  <= '0;
                end
            end else if (baud_cnt == LAST) begin
                baud_cnt <= '0;
            end else begin
                baud_cnt <= baud_cnt + 1'b1;
            end

            if (rx_en_sig && mid) begin
                if (state == DATA) begin
                    shift   <= {level, shift[UART_DATA_BITS-1:1]};
                    bit_cnt <= bit_cnt + 1'b1;
                end
                if (state == STOP) begin
                    rx_data   <= shift;
                    frame_err <= ~level;
                end
            end
        end
    end

`ifdef RX_PARITY_EN
    logic par_acc;
    logic par_bad;

    always_ff @(posedge sysclk) begin
        if (rst) begin
            par_acc    <= 1'b0;
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            if (state == IDLE && fall) begin
                par_acc <= 1'b0;
                par_bad <= 1'b0;
            end
            if (rx_en_sig && mid) begin
                if (state == DATA) par_acc <= par_acc ^ level;
                if (state == PARITY) par_bad <= (level != (par_acc ^ PARITY_MODE));
                if (state == STOP) parity_err <= par_bad;
            end
        end
    end
`else
    assign parity_err = 1'b0 & PARITY_MODE;
`endif

endmodule

// File: tb/tb_rx_frame_module.sv
// Directed bench for rx_frame_module with CLKS_PER_BIT=16; frame length and
// parity expectations follow whether RX_PARITY_EN is defined.
module tb_rx_frame_module;

    localparam int   C    = 16;
    localparam logic MODE = 1'b0;
`ifdef RX_PARITY_EN
    localparam int   NB     = 11;
    localparam logic PAR_EN = 1'b1;
`else
    localparam int   NB     = 10;
    localparam logic PAR_EN = 1'b0;
`endif
    // Cycles from the pin drive cycle to the strobe: 2 to T0, half bit, (NB-1) bits, +1.
    localparam int DONE_OFS = 2 + C / 2 + (NB - 1) * C + 1;

    logic       sysclk = 1'b0;
    logic       rst;
    logic       rx_en_sig;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_done_sig;
    logic       rx_busy;
    logic       parity_err;
    logic       frame_err;

    rx_frame_module #(
        .CLKS_PER_BIT (C),
        .PARITY_MODE  (MODE)
    ) dut (
        .sysclk      (sysclk),
        .rst         (rst),
        .rx_en_sig   (rx_en_sig),
        .rx          (rx),
        .rx_data     (rx_data),
        .rx_done_sig (rx_done_sig),
        .rx_busy     (rx_busy),
        .parity_err  (parity_err),
        .frame_err   (frame_err)
    );

    always #5 sysclk = ~sysclk;

    int cyc = 0;
    always @(posedge sysclk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    int         strobes = 0;
    int         strobe_cyc = 0;
    logic [7:0] s_data;
    logic       s_perr;
    logic       s_ferr;
    logic       s_busy;

    always @(negedge sysclk) begin
        if (rx_done_sig === 1'b1) begin
            strobes    = strobes + 1;
            strobe_cyc = cyc;
            s_data     = rx_data;
            s_perr     = parity_err;
            s_ferr     = frame_err;
            s_busy     = rx_busy;
        end
    end

    typedef struct {
        logic [7:0] data;
        logic       flip;
        logic       stop;
        logic [7:0] exp_data;
        logic       exp_perr;
        logic       exp_ferr;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge sysclk);
        #1;
    endtask

    task automatic sample_at(input int k);
        @(negedge sysclk);
        while (cyc < k) @(negedge sysclk);
    endtask

    // Called just after a rising edge; returns the cycle the start bit was driven.
    task automatic send_frame(input logic [7:0] d, input logic flip, input logic stop,
                              output int c0);
        c0 = cyc;
        rx = 1'b0;
        tick(C);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            tick(C);
        end
        if (PAR_EN) begin
            rx = ^d ^ MODE ^ flip;
            tick(C);
        end
        rx = stop;
        tick(C);
        rx = 1'b1;
    endtask

    task automatic run_frame(input string tag, input vec_t v);
        int c0;
        int n0;
        n0 = strobes;
        send_frame(v.data, v.flip, v.stop, c0);
        tick(4);
        check({tag, "_strobes"}, strobes - n0, 1);
        check({tag, "_strobe_cycle"}, strobe_cyc - c0, DONE_OFS);
        check({tag, "_data"}, s_data, v.exp_data);
        check({tag, "_parity_err"}, s_perr, PAR_EN ? v.exp_perr : 1'b0);
        check({tag, "_frame_err"}, s_ferr, v.exp_ferr);
        check({tag, "_busy_at_done"}, s_busy, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int c1;
        int n0;
        vec_t v;

        vecs[0] = '{8'h55, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0};
        vecs[1] = '{8'hA3, 1'b1, 1'b1, 8'hA3, 1'b1, 1'b0};
        vecs[2] = '{8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
        vecs[3] = '{8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
        vecs[4] = '{8'h80, 1'b1, 1'b1, 8'h80, 1'b1, 1'b0};
        vecs[5] = '{8'h0F, 1'b0, 1'b0, 8'h0F, 1'b0, 1'b1};

        rst = 1'b1;
        rx = 1'b1;
        rx_en_sig = 1'b1;
        tick(3);
        @(negedge sysclk);
        check("rst_data", rx_data, 8'h00);
        check("rst_done", rx_done_sig, 1'b0);
        check("rst_busy", rx_busy, 1'b0);
        check("rst_parity_err", parity_err, 1'b0);
        check("rst_frame_err", frame_err, 1'b0);
        tick(1);
        rst = 1'b0;
        tick(5);

        for (int i = 0; i < 6; i++) begin
            run_frame($sformatf("vec%0d", i), vecs[i]);
        end

        // Short low pulse: start rejected at the half-bit sample.
        n0 = strobes;
        c0 = cyc;
        rx = 1'b0;
        tick(3);
        sample_at(c0 + 3);
        check("glitch_busy_t0p1", rx_busy, 1'b1);
        tick(1);
        rx = 1'b1;
        sample_at(c0 + 10);
        check("glitch_busy_t0p8", rx_busy, 1'b1);
        sample_at(c0 + 11);
        check("glitch_busy_t0p9", rx_busy, 1'b0);
        tick(3 * C);
        check("glitch_no_strobe", strobes - n0, 0);
        check("glitch_data_kept", rx_data, 8'h0F);

        // Enable dropped mid-frame.
        n0 = strobes;
        c0 = cyc;
        rx = 1'b0;
        tick(C);
        for (int i = 0; i < 3; i++) begin
            rx = i[0];
            tick(C);
        end
        rx_en_sig = 1'b0;
        sample_at(c0 + 4 * C);
        check("abort_busy_before", rx_busy, 1'b1);
        sample_at(c0 + 4 * C + 1);
        check("abort_busy_after", rx_busy, 1'b0);
        tick(1);
        rx = 1'b1;
        tick(3 * C);
        rx_en_sig = 1'b1;
        tick(C);
        check("abort_no_strobe", strobes - n0, 0);
        check("abort_data_kept", rx_data, 8'h0F);
        check("abort_ferr_kept", frame_err, 1'b1);

        // Reset in the middle of data bit 4 of 0x81.
        n0 = strobes;
        v.data = 8'h81;
        rx = 1'b0;
        tick(C);
        for (int i = 0; i < 5; i++) begin
            rx = v.data[i];
            tick(i == 4 ? C / 2 : C);
        end
        rst = 1'b1;
        rx = 1'b1;
        tick(1);
        rst = 1'b0;
        @(negedge sysclk);
        check("midrst_data", rx_data, 8'h00);
        check("midrst_done", rx_done_sig, 1'b0);
        check("midrst_busy", rx_busy, 1'b0);
        check("midrst_parity_err", parity_err, 1'b0);
        check("midrst_frame_err", frame_err, 1'b0);
        tick(3 * C);
        check("midrst_no_strobe", strobes - n0, 0);
        run_frame("after_rst", '{8'h3C, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0});

        // Back-to-back frames with no idle gap.
        n0 = strobes;
        send_frame(8'h01, 1'b0, 1'b1, c0);
        c1 = strobe_cyc;
        check("b2b_first_data", s_data, 8'h01);
        send_frame(8'hFE, 1'b0, 1'b1, c0);
        tick(4);
        check("b2b_strobes", strobes - n0, 2);
        check("b2b_spacing", strobe_cyc - c1, NB * C);
        check("b2b_second_data", s_data, 8'hFE);
        check("b2b_errs", {s_perr, s_ferr}, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
